// File: rtl/image_cache_reader.sv
// Raster-order read sequencer for the image cache: issues reads and turns 1-cycle-latency data into a valid/ready pixel stream.
// Define IMAGE_CACHE_READER_ROI_EN to add a region-of-interest scan window latched at start.
module image_cache_reader #(
  parameter int IMG_W     = 320,
  parameter int IMG_H     = 240,
  parameter int X_WIDTH   = 9,
  parameter int Y_WIDTH   = 8,
  parameter int WORD_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [Y_WIDTH-1:0]   raddr_y,
  output logic [X_WIDTH-1:0]   raddr_x,
  input  logic [WORD_SIZE-1:0] q,
`ifdef IMAGE_CACHE_READER_ROI_EN
  input  logic [X_WIDTH-1:0]   roi_x0,
  input  logic [Y_WIDTH-1:0]   roi_y0,
  input  logic [X_WIDTH:0]     roi_w,
  input  logic [Y_WIDTH:0]     roi_h,
`endif
  output logic [WORD_SIZE-1:0] pix_data,
  output logic [X_WIDTH-1:0]   pix_x,
  output logic [Y_WIDTH-1:0]   pix_y,
  output logic                 pix_eol,
  output logic                 pix_eof,
  output logic                 pix_valid,
  input  logic                 pix_ready
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t               state;
  logic [X_WIDTH-1:0]   scan_x0, scan_x1, load_x;
  logic [Y_WIDTH-1:0]   scan_y1, load_y;
  logic                 scan_empty;

  logic                 inflight;
  logic [X_WIDTH-1:0]   if_x;
  logic [Y_WIDTH-1:0]   if_y;
  logic                 if_eol, if_eof;

  logic [WORD_SIZE-1:0] tail_data;
  logic [X_WIDTH-1:0]   tail_x;
  logic [Y_WIDTH-1:0]   tail_y;
  logic                 tail_eol, tail_eof, tail_valid;

`ifdef IMAGE_CACHE_READER_ROI_EN
  assign load_x     = roi_x0;
  assign load_y     = roi_y0;
  assign scan_empty = (roi_w == '0) || (roi_h == '0);

  // Window bounds are frozen at start so ROI inputs may change mid-scan.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_x0 <= '0;
      scan_x1 <= '0;
      scan_y1 <= '0;
    end else if (state == S_IDLE && start) begin
      scan_x0 <= roi_x0;
      scan_x1 <= X_WIDTH'(32'(roi_x0) + 32'(roi_w) - 32'd1);
      scan_y1 <= Y_WIDTH'(32'(roi_y0) + 32'(roi_h) - 32'd1);
    end
  end
`else
  assign load_x     = '0;
  assign load_y     = '0;
  assign scan_empty = 1'b0;
  assign scan_x0    = '0;
  assign scan_x1    = X_WIDTH'(IMG_W - 1);
  assign scan_y1    = Y_WIDTH'(IMG_H - 1);
`endif

  logic       x_at_end, y_at_end, pop, issue;
  logic [1:0] occupancy;

  assign x_at_end  = (raddr_x == scan_x1);
  assign y_at_end  = (raddr_y == scan_y1);
  assign pop       = pix_valid & pix_ready;
  assign occupancy = {1'b0, pix_valid} + {1'b0, tail_valid} + {1'b0, inflight};
  // A read may only be launched if its data is guaranteed a FIFO slot when it returns.
  assign issue     = (state == S_RUN) && ((occupancy < 2'd2) || pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      raddr_x  <= '0;
      raddr_y  <= '0;
      inflight <= 1'b0;
      if_x     <= '0;
      if_y     <= '0;
      if_eol   <= 1'b0;
      if_eof   <= 1'b0;
    end else begin
      inflight <= issue;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (scan_empty) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state   <= S_RUN;
              raddr_x <= load_x;
              raddr_y <= load_y;
            end
          end
        end
        S_RUN: begin
          if (issue) begin
            if_x   <= raddr_x;
            if_y   <= raddr_y;
            if_eol <= x_at_end;
            if_eof <= x_at_end && y_at_end;
            if (x_at_end && y_at_end) begin
              state <= S_DRAIN;
            end else if (x_at_end) begin
              raddr_x <= scan_x0;
              raddr_y <= raddr_y + 1'b1;
            end else begin
              raddr_x <= raddr_x + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (pop && pix_eof) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Two-entry FIFO whose head register drives the stream outputs directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_eol    <= 1'b0;
      pix_eof    <= 1'b0;
      tail_valid <= 1'b0;
      tail_data  <= '0;
      tail_x     <= '0;
      tail_y     <= '0;
      tail_eol   <= 1'b0;
      tail_eof   <= 1'b0;
    end else if (pop) begin
      if (tail_valid) begin
        pix_data <= tail_data;
        pix_x    <= tail_x;
        pix_y    <= tail_y;
        pix_eol  <= tail_eol;
        pix_eof  <= tail_eof;
        if (inflight) begin
          tail_data <= q;
          tail_x    <= if_x;
          tail_y    <= if_y;
          tail_eol  <= if_eol;
          tail_eof  <= if_eof;
        end else begin
          tail_valid <= 1'b0;
        end
      end else if (inflight) begin
        pix_data <= q;
        pix_x    <= if_x;
        pix_y    <= if_y;
        pix_eol  <= if_eol;
        pix_eof  <= if_eof;
      end else begin
        pix_valid <= 1'b0;
      end
    end else if (inflight) begin
      if (!pix_valid) begin
        pix_valid <= 1'b1;
        pix_data  <= q;
        pix_x     <= if_x;
        pix_y     <= if_y;
        pix_eol   <= if_eol;
        pix_eof   <= if_eof;
      end else begin
        tail_valid <= 1'b1;
        tail_data  <= q;
        tail_x     <= if_x;
        tail_y     <= if_y;
        tail_eol   <= if_eol;
        tail_eof   <= if_eof;
      end
    end
  end

endmodule

// File: tb/tb_image_cache_reader.sv
// Directed bench for image_cache_reader on a 4x3 frame with a cache model returning {y,x}.
module tb_image_cache_reader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       busy, done;
  logic [1:0] raddr_y, raddr_x;
  logic [3:0] q;
  logic [3:0] pix_data;
  logic [1:0] pix_x, pix_y;
  logic       pix_eol, pix_eof, pix_valid;
  logic       pix_ready;
`ifdef IMAGE_CACHE_READER_ROI_EN
  logic [1:0] roi_x0 = 2'd0;
  logic [1:0] roi_y0 = 2'd0;
  logic [2:0] roi_w  = 3'd4;
  logic [2:0] roi_h  = 3'd3;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] x;
    logic [1:0] y;
    logic       eol;
    logic       eof;
  } pix_rec_t;

  pix_rec_t exp_tab[12];

  image_cache_reader #(
    .IMG_W(4), .IMG_H(3), .X_WIDTH(2), .Y_WIDTH(2), .WORD_SIZE(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .raddr_y(raddr_y), .raddr_x(raddr_x), .q(q),
`ifdef IMAGE_CACHE_READER_ROI_EN
    .roi_x0(roi_x0), .roi_y0(roi_y0), .roi_w(roi_w), .roi_h(roi_h),
`endif
    .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .pix_eol(pix_eol),
    .pix_eof(pix_eof), .pix_valid(pix_valid), .pix_ready(pix_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) q <= {raddr_y, raddr_x};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
    checkOutput("first_raddr", {28'd0, raddr_y, raddr_x}, {28'd0, exp_tab[0].y, exp_tab[0].x});
  endtask

  // mode 0: ready always high; mode 1: ready random
  task automatic consumeFrame(input int n, input int mode, input bit timed);
    int idx = 0, cyc = 0, first_hs = -1, last_hs = -1, done_cyc = -1;
    bit held = 1'b0;
    logic [9:0] hv = '0;
    while (done_cyc < 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (held)
        checkOutput("hold_stable", {22'd0, pix_data, pix_y, pix_x, pix_eol, pix_eof}, {22'd0, hv});
      if (done) begin
        done_cyc = cyc;
        held = 1'b0;
        checkOutput("busy_with_done", {31'd0, busy}, 32'd1);
      end else begin
        pix_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (pix_valid && pix_ready) begin
          if (idx < n) begin
            checkOutput("pix_x", {30'd0, pix_x}, {30'd0, exp_tab[idx].x});
            checkOutput("pix_y", {30'd0, pix_y}, {30'd0, exp_tab[idx].y});
            checkOutput("pix_data", {28'd0, pix_data}, {28'd0, exp_tab[idx].y, exp_tab[idx].x});
            checkOutput("pix_eol", {31'd0, pix_eol}, {31'd0, exp_tab[idx].eol});
            checkOutput("pix_eof", {31'd0, pix_eof}, {31'd0, exp_tab[idx].eof});
          end else begin
            checkOutput("extra_pixel", idx, n - 1);
          end
          if (first_hs < 0) first_hs = cyc;
          last_hs = cyc;
          idx++;
          held = 1'b0;
        end else begin
          held = pix_valid;
          hv = {pix_data, pix_y, pix_x, pix_eol, pix_eof};
        end
      end
    end
    pix_ready = 1'b1;
    checkOutput("done_seen", {31'd0, done_cyc >= 0}, 32'd1);
    checkOutput("pixel_count", idx, n);
    checkOutput("done_after_last", done_cyc - last_hs, 1);
    if (timed) begin
      checkOutput("first_latency", first_hs, 2);
      checkOutput("throughput", last_hs - first_hs, n - 1);
    end
    @(negedge clk);
    checkOutput("done_pulse_end", {31'd0, done}, 32'd0);
    checkOutput("busy_end", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int hs;
    bit seen_done;

    exp_tab = '{
      '{2'd0, 2'd0, 1'b0, 1'b0}, '{2'd1, 2'd0, 1'b0, 1'b0}, '{2'd2, 2'd0, 1'b0, 1'b0}, '{2'd3, 2'd0, 1'b1, 1'b0},
      '{2'd0, 2'd1, 1'b0, 1'b0}, '{2'd1, 2'd1, 1'b0, 1'b0}, '{2'd2, 2'd1, 1'b0, 1'b0}, '{2'd3, 2'd1, 1'b1, 1'b0},
      '{2'd0, 2'd2, 1'b0, 1'b0}, '{2'd1, 2'd2, 1'b0, 1'b0}, '{2'd2, 2'd2, 1'b0, 1'b0}, '{2'd3, 2'd2, 1'b1, 1'b1}
    };

    reset_n   = 1'b0;
    start     = 1'b0;
    pix_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_valid", {31'd0, pix_valid}, 32'd0);
    checkOutput("rst_raddr", {28'd0, raddr_y, raddr_x}, 32'd0);
    reset_n = 1'b1;

    $display("[TB] full-rate frame");
    applyStimulus();
    consumeFrame(12, 0, 1'b1);

    $display("[TB] random backpressure frame");
    applyStimulus();
    consumeFrame(12, 1, 1'b0);

    $display("[TB] stalled consumer");
    pix_ready = 1'b0;
    applyStimulus();
    pix_ready = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("stall_reads_issued", {28'd0, raddr_y, raddr_x}, {28'd0, 2'd0, 2'd2});
    checkOutput("stall_valid", {31'd0, pix_valid}, 32'd1);
    checkOutput("stall_head", {28'd0, pix_y, pix_x}, 32'd0);
    consumeFrame(12, 0, 1'b0);

    $display("[TB] start held high");
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    consumeFrame(12, 0, 1'b1);
    @(negedge clk);
    checkOutput("restart_busy", {31'd0, busy}, 32'd1);
    start = 1'b0;
    consumeFrame(12, 0, 1'b0);

    $display("[TB] reset mid-frame");
    applyStimulus();
    hs = 0;
    for (int i = 0; i < 30 && hs < 5; i++) begin
      @(negedge clk);
      pix_ready = 1'b1;
      if (pix_valid) hs++;
    end
    checkOutput("pre_reset_count", hs, 5);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_rst_valid", {31'd0, pix_valid}, 32'd0);
    checkOutput("mid_rst_data", {28'd0, pix_data}, 32'd0);
    checkOutput("mid_rst_pos", {28'd0, pix_y, pix_x}, 32'd0);
    checkOutput("mid_rst_raddr", {28'd0, raddr_y, raddr_x}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    checkOutput("no_done_after_reset", {31'd0, seen_done}, 32'd0);
    applyStimulus();
    consumeFrame(12, 0, 1'b1);

`ifdef IMAGE_CACHE_READER_ROI_EN
    $display("[TB] ROI window");
    exp_tab[0] = '{2'd1, 2'd1, 1'b0, 1'b0};
    exp_tab[1] = '{2'd2, 2'd1, 1'b1, 1'b0};
    exp_tab[2] = '{2'd1, 2'd2, 1'b0, 1'b0};
    exp_tab[3] = '{2'd2, 2'd2, 1'b1, 1'b1};
    roi_x0 = 2'd1; roi_y0 = 2'd1; roi_w = 3'd2; roi_h = 3'd2;
    applyStimulus();
    consumeFrame(4, 0, 1'b1);
    roi_w = 3'd0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("roi_empty_done", {31'd0, done}, 32'd1);
    checkOutput("roi_empty_valid", {31'd0, pix_valid}, 32'd0);
    @(negedge clk);
    checkOutput("roi_empty_idle", {30'd0, busy, done}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
